sbox_subbytes_seq: RTL and testbench
====================================

// Module: sbox_subbytes_seq
// PURPOSE
//   Sequences a full AES SubBytes over an NUM_BYTES-byte state using one shared
//   combinational sbox_lookup, one byte per clock. Sits between the control logic and
//   sbox_lookup: drives sbox address/mode, collects the substituted bytes, and reports
//   completion through a start/busy/done handshake. Serves encrypt (S) and decrypt (InvS).
// PARAMETERS
//   NUM_BYTES  16  bytes per state; 4 = single word mode; legal range 1..16
// PORTS
//   clk           in   1             system clock (CLOCK_50 at top level)
//   reset_n       in   1             asynchronous, active-low reset
//   start         in   1             request; sampled only when busy=0
//   encrypt       in   1             1 = forward S-box, 0 = inverse; captured with start
//   abort         in   1             synchronous cancel of a running operation
//   state_in      in   8*NUM_BYTES   input state; byte k = bits [8k+7:8k]
//   state_out     out  8*NUM_BYTES   substituted state; valid from done until next done
//   busy          out  1             operation in progress
//   done          out  1             one-cycle pulse, state_out updated this cycle
//   sbox_addr     out  8             to sbox_lookup.address
//   sbox_encrypt  out  1             to sbox_lookup.encrypt
//   sbox_data     in   8             from sbox_lookup.data_out (combinational, same cycle)
// BEHAVIOUR
//   Reset (reset_n=0, async): FSM=IDLE, cnt=0, work=0, state_out=0, busy=0, done=0,
//     sbox_addr=0, sbox_encrypt=1.
//   FSM: IDLE, RUN, DONE. Counter cnt width $clog2(NUM_BYTES)+1.
//   IDLE: start=1 -> load work<=state_in, mode<=encrypt, cnt<=0, go RUN.
//   RUN: sbox_addr=work[7:0], sbox_encrypt=mode; each edge work<={sbox_data,work[top:8]}
//     (shift right one byte), cnt++. Byte 0 goes first, byte NUM_BYTES-1 last.
//     On edge where cnt==NUM_BYTES-1: state_out<={sbox_data,work[top:8]}, go DONE.
//   DONE: done=1, busy=0 for exactly one cycle; start=1 here is accepted (back-to-back),
//     next state RUN with new load; otherwise IDLE.
//   busy=1 only in RUN. start in RUN ignored (not queued).
//   Latency: start sampled at edge T -> done high in cycle after edge T+NUM_BYTES;
//     throughput NUM_BYTES+1 cycles per state.
//   abort=1 in RUN -> IDLE next edge; no done; state_out keeps previous result;
//     abort priority over last-byte completion. abort in IDLE/DONE: no effect.
//   sbox_addr=0 outside RUN; sbox_encrypt holds last captured mode.
//   encrypt/state_in changes during RUN have no effect (captured at start).
//   reset_n asserted mid-RUN: immediate return to reset values, done never pulses.
// STRUCTURE
//   Shared include aes_defs.vh: FSM state localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2),
//     AES_BYTE_W=8, AES_STATE_BYTES=16.
//   Block is flat: FSM + counter + shift register. sbox_lookup is instanced beside it
//     at top level (not inside) so other users can later share it via an arbiter.
// TESTING (bench instantiates sbox_lookup wired to sbox_* ports)
//   state_in=all 8'h00, encrypt=1, start pulse -> busy 16 cycles, done pulse, state_out=all 8'h63.
//   state_in bytes 0..3 = 00,01,53,FF (rest 00), encrypt=1 -> state_out bytes 63,7C,ED,16, rest 63.
//   Result of previous test fed back with encrypt=0 -> original state_in restored exactly.
//   Abort at 5th RUN cycle -> IDLE next cycle, no done, state_out equals prior result; re-start completes normally.
//   start held high continuously -> done every 17 cycles, no lost/duplicated result; start during RUN ignored.
//   reset_n low mid-RUN -> all outputs to reset values asynchronously; NUM_BYTES=4 run -> done after 4 RUN cycles.

Source files
------------

// File: rtl/sbox_subbytes_seq_pkg.sv
// Shared AES SubBytes definitions: FSM encoding, byte widths and GF(2^8) helpers
// used by the sequencer and the shared S-box.
package sbox_subbytes_seq_pkg;

  localparam int AES_BYTE_W      = 8;
  localparam int AES_STATE_BYTES = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    return 8'((x << k) | (x >> (8 - k)));
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h00;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ s;
      s = xtime(s);
    end
    return r;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] x);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] x);
    return rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
  endfunction

endpackage

// File: rtl/sbox_subbytes_seq_sbox.sv
// Combinational AES S-box / inverse S-box, kept outside the sequencer so it can
// later be shared between several users through an arbiter.
module sbox_lookup
  import sbox_subbytes_seq_pkg::*;
(
  input  logic [7:0] address,
  input  logic       encrypt,
  output logic [7:0] data_out
);

  assign data_out = encrypt ? affine_fwd(gf_inv(address)) : gf_inv(affine_inv(address));

endmodule

// File: rtl/sbox_subbytes_seq.sv
// Byte-serial SubBytes sequencer: streams the captured state through one external
// S-box, one byte per clock, with a start/busy/done handshake and abort.
module sbox_subbytes_seq
  import sbox_subbytes_seq_pkg::*;
#(
  parameter int NUM_BYTES = AES_STATE_BYTES
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic                            encrypt,
  input  logic                            abort,
  input  logic [AES_BYTE_W*NUM_BYTES-1:0] state_in,
  output logic [AES_BYTE_W*NUM_BYTES-1:0] state_out,
  output logic                            busy,
  output logic                            done,
  output logic [7:0]                      sbox_addr,
  output logic                            sbox_encrypt,
  input  logic [7:0]                      sbox_data
);

  localparam int W  = AES_BYTE_W * NUM_BYTES;
  localparam int CW = $clog2(NUM_BYTES) + 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    work_q, work_d;
  logic [W-1:0]    out_q, out_d;
  logic            mode_q, mode_d;
  logic [W-1:0]    shifted;

  // Substituted byte enters at the top so byte 0 is always the one being looked up.
  if (NUM_BYTES == 1) begin : g_one
    assign shifted = sbox_data;
  end else begin : g_multi
    assign shifted = {sbox_data, work_q[W-1:AES_BYTE_W]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      out_q   <= '0;
      mode_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      out_q   <= out_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    out_d   = out_q;
    mode_d  = mode_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          work_d  = state_in;
          mode_d  = encrypt;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort wins even on the last byte; the previous result stays visible.
        if (abort) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          work_d = shifted;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            out_d   = shifted;
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy         = (state_q == ST_RUN);
  assign done         = (state_q == ST_DONE);
  assign sbox_addr    = busy ? work_q[7:0] : 8'h00;
  assign sbox_encrypt = mode_q;
  assign state_out    = out_q;

endmodule

// File: tb/tb_sbox_subbytes_seq.sv
// Bench for sbox_subbytes_seq: fixed vectors, random ops against a log-table S-box
// model, abort, back-to-back, async reset and a 4-byte instance.
module tb_sbox_subbytes_seq;

  logic         clk = 1'b0;
  logic         reset_n, start, encrypt, abort;
  logic [127:0] state_in, state_out;
  logic         busy, done, sbox_encrypt;
  logic [7:0]   sbox_addr, sbox_data;

  logic         start4;
  logic [31:0]  state_in4, state_out4;
  logic         busy4, done4, sbox_encrypt4;
  logic [7:0]   sbox_addr4, sbox_data4;

  int nerr = 0;
  int nchk = 0;

  logic [7:0] sb [256];
  logic [7:0] isb[256];

  always #5 clk = ~clk;

  sbox_subbytes_seq #(.NUM_BYTES(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .encrypt(encrypt), .abort(abort),
    .state_in(state_in), .state_out(state_out), .busy(busy), .done(done),
    .sbox_addr(sbox_addr), .sbox_encrypt(sbox_encrypt), .sbox_data(sbox_data));
  sbox_lookup u_sb (.address(sbox_addr), .encrypt(sbox_encrypt), .data_out(sbox_data));

  sbox_subbytes_seq #(.NUM_BYTES(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .encrypt(1'b1), .abort(1'b0),
    .state_in(state_in4), .state_out(state_out4), .busy(busy4), .done(done4),
    .sbox_addr(sbox_addr4), .sbox_encrypt(sbox_encrypt4), .sbox_data(sbox_data4));
  sbox_lookup u_sb4 (.address(sbox_addr4), .encrypt(sbox_encrypt4), .data_out(sbox_data4));

  typedef struct {
    logic [127:0] din;
    logic         enc;
    logic [127:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference tables from the generator-3 log/antilog construction plus the affine map.
  task automatic build_tables();
    logic [7:0] ex[255];
    int         lg[256];
    logic [7:0] p, inv, b, c;
    c = 8'h63;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = p;
      lg[p] = i;
      p = p ^ ({p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00));
    end
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
      for (int i = 0; i < 8; i++)
        b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x]  = b;
      isb[b] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] d, input logic e, input int n);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = e ? sb[d[8*k +: 8]] : isb[d[8*k +: 8]];
    return r;
  endfunction

  // One start pulse; inputs are scrambled once running to show they were captured.
  task automatic do_op(input logic [127:0] din, input logic enc,
                       output logic [127:0] dout, output int busy_cyc, output bit got_done);
    @(negedge clk);
    state_in = din; encrypt = enc; start = 1'b1;
    @(negedge clk);
    start = 1'b0; state_in = ~din; encrypt = ~enc;
    busy_cyc = 0; got_done = 0;
    for (int i = 0; i < 100 && !got_done; i++) begin
      if (done) got_done = 1;
      else begin
        if (busy) busy_cyc++;
        @(negedge clk);
      end
    end
    dout = state_out;
  endtask

  initial begin
    vec_t         vecs[3];
    logic [127:0] res, prior, din, v[4];
    int           bc, gap, k;
    bit           gd, seen;
    logic         e;

    build_tables();
    vecs[0] = '{din: '0, enc: 1'b1, exp: {16{8'h63}}};
    vecs[1] = '{din: 128'h0000_0000_0000_0000_0000_0000_FF53_0100, enc: 1'b1,
                exp: {{12{8'h63}}, 32'h16ED_7C63}};
    vecs[2] = '{din: vecs[1].exp, enc: 1'b0, exp: vecs[1].din};

    reset_n = 1'b0; start = 0; encrypt = 1; abort = 0; state_in = '0;
    start4 = 0; state_in4 = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", sbox_addr, 0);
    chk("rst_enc", sbox_encrypt, 1);
    chk("rst_out", state_out, 0);
    @(negedge clk) reset_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      do_op(vecs[i].din, vecs[i].enc, res, bc, gd);
      chk($sformatf("vec%0d_done", i), gd, 1);
      chk($sformatf("vec%0d_busy", i), bc, 16);
      chk($sformatf("vec%0d_out", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_model", i), res, model(vecs[i].din, vecs[i].enc, 16));
    end
    @(negedge clk);
    chk("idle_addr", sbox_addr, 0);
    chk("idle_mode_hold", sbox_encrypt, 0);

    for (int i = 0; i < 20; i++) begin
      din = {$urandom, $urandom, $urandom, $urandom};
      e = 1'($urandom_range(0, 1));
      do_op(din, e, res, bc, gd);
      chk($sformatf("rnd%0d_done", i), gd, 1);
      chk($sformatf("rnd%0d_out", i), res, model(din, e, 16));
    end

    // Abort on the 5th RUN cycle.
    prior = state_out;
    din = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk); state_in = din; encrypt = 1; start = 1;
    @(negedge clk); start = 0;
    repeat (4) @(negedge clk);
    chk("ab_busy5", busy, 1);
    chk("ab_addr5", sbox_addr, din[39:32]);
    abort = 1;
    @(negedge clk); abort = 0;
    chk("ab_idle", busy, 0);
    chk("ab_nodone", done, 0);
    seen = 0;
    repeat (20) begin @(negedge clk); if (done || busy) seen = 1; end
    chk("ab_quiet", seen, 0);
    chk("ab_keep", state_out, prior);

    // Abort on the final byte still suppresses done.
    @(negedge clk); state_in = din; start = 1;
    @(negedge clk); start = 0;
    repeat (15) @(negedge clk);
    abort = 1;
    @(negedge clk); abort = 0;
    seen = 0;
    repeat (5) begin if (done) seen = 1; @(negedge clk); end
    chk("ab_last_nodone", seen, 0);
    chk("ab_last_keep", state_out, prior);

    do_op(din, 1'b1, res, bc, gd);
    chk("ab_restart_done", gd, 1);
    chk("ab_restart_busy", bc, 16);
    chk("ab_restart_out", res, model(din, 1'b1, 16));

    // start held high: one result every 17 cycles, each matched to its own input.
    for (int i = 0; i < 4; i++) v[i] = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk); state_in = v[0]; encrypt = 1; start = 1;
    k = 0; gap = 0;
    for (int c = 0; c < 200 && k < 4; c++) begin
      @(negedge clk);
      gap++;
      if (done) begin
        chk($sformatf("b2b%0d_gap", k), gap, 17);
        chk($sformatf("b2b%0d_out", k), state_out, model(v[k], 1'b1, 16));
        gap = 0;
        k++;
        if (k < 4) state_in = v[k];
      end
    end
    chk("b2b_count", k, 4);
    start = 0;
    repeat (20) @(negedge clk);

    // Async reset mid-run.
    chk("pre_rst_nonzero", (state_out != 0), 1);
    @(negedge clk); state_in = din; start = 1;
    @(negedge clk); start = 0;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_addr", sbox_addr, 0);
    chk("mrst_enc", sbox_encrypt, 1);
    chk("mrst_out", state_out, 0);
    @(negedge clk) reset_n = 1'b1;
    seen = 0;
    repeat (20) begin @(negedge clk); if (done || busy) seen = 1; end
    chk("mrst_nodone", seen, 0);

    // 4-byte instance.
    for (int i = 0; i < 3; i++) begin
      din = {96'h0, $urandom};
      @(negedge clk); state_in4 = din[31:0]; start4 = 1;
      @(negedge clk); start4 = 0;
      bc = 0; gd = 0;
      for (int c = 0; c < 50 && !gd; c++) begin
        if (done4) gd = 1;
        else begin if (busy4) bc++; @(negedge clk); end
      end
      chk($sformatf("n4_%0d_done", i), gd, 1);
      chk($sformatf("n4_%0d_busy", i), bc, 4);
      chk($sformatf("n4_%0d_out", i), {96'h0, state_out4}, model(din, 1'b1, 4));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
